// File: rtl/wb_stage.sv
// Write-back stage: load formatting, register-file write port, HI/LO registers and retire counter.
// Optional trace outputs are enabled by defining WB_DEBUG_TRACE_EN.
module wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_stall,
    input  logic [3:0]  MEM_WB_load_type_data,
    input  logic [3:0]  MEM_WB_byte_valid_data,
    input  logic [1:0]  MEM_WB_result_sel_data,
    input  logic        MEM_WB_SC_result_sel_data,
    input  logic        MEM_WB_wreg_data,
    input  logic        MEM_WB_whi_data,
    input  logic        MEM_WB_wlo_data,
    input  logic        MEM_WB_hi_i_sel_data,
    input  logic        MEM_WB_lo_i_sel_data,
    input  logic [4:0]  MEM_WB_regdst_data,
    input  logic [31:0] MEM_WB_ALU_result_data,
    input  logic [31:0] MEM_WB_mem_rdata_data,
    input  logic [31:0] MEM_WB_rf_rdata0_fw_data,
    input  logic [31:0] MEM_WB_rf_rdata1_fw_data,
    input  logic [31:0] MEM_WB_PC_plus4_data,
    input  logic [31:0] MEM_WB_Instruction_data,
    input  logic [63:0] MEM_WB_MulDiv_result_data,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] hi_fw,
    output logic [31:0] lo_fw,
    output logic [31:0] retire_cnt
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
`endif
);

    typedef enum logic [3:0] {
        LT_LW  = 4'd0,
        LT_LB  = 4'd1,
        LT_LBU = 4'd2,
        LT_LH  = 4'd3,
        LT_LHU = 4'd4,
        LT_LWL = 4'd5,
        LT_LWR = 4'd6
    } load_type_e;

    typedef enum logic [1:0] {
        RS_ALU    = 2'd0,
        RS_LOAD   = 2'd1,
        RS_LINK   = 2'd2,
        RS_MULDIV = 2'd3
    } result_sel_e;

    load_type_e  load_type;
    result_sel_e result_sel;
    logic [1:0]  offset;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] formatted;
    logic [31:0] load_result;
    logic [31:0] link_value;
    logic        hi_we;
    logic        lo_we;
    logic        retire_en;
    logic [31:0] hi_next;
    logic [31:0] lo_next;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] cnt_q;

    assign load_type  = load_type_e'(MEM_WB_load_type_data);
    assign result_sel = result_sel_e'(MEM_WB_result_sel_data);
    assign offset     = MEM_WB_ALU_result_data[1:0];
    assign byte_sel   = 8'(MEM_WB_mem_rdata_data >> {offset, 3'b000});
    assign half_sel   = offset[1] ? MEM_WB_mem_rdata_data[31:16] : MEM_WB_mem_rdata_data[15:0];
    assign link_value = MEM_WB_PC_plus4_data + 32'd4;

    // LWL shifts left by 8*(3-o); ~o equals 3-o for a 2-bit offset
    always_comb begin
        formatted = MEM_WB_mem_rdata_data;
        case (load_type)
            LT_LB:   formatted = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  formatted = {24'd0, byte_sel};
            LT_LH:   formatted = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  formatted = {16'd0, half_sel};
            LT_LWL:  formatted = MEM_WB_mem_rdata_data << {~offset, 3'b000};
            LT_LWR:  formatted = MEM_WB_mem_rdata_data >> {offset, 3'b000};
            default: formatted = MEM_WB_mem_rdata_data;
        endcase
    end

    always_comb begin
        load_result = MEM_WB_rf_rdata1_fw_data;
        for (int unsigned i = 0; i < 4; i++) begin
            if (MEM_WB_byte_valid_data[i])
                load_result[8*i +: 8] = formatted[8*i +: 8];
        end
    end

    always_comb begin
        rf_wdata = MEM_WB_ALU_result_data;
        if (MEM_WB_SC_result_sel_data) begin
            rf_wdata = 32'd1;
        end else begin
            case (result_sel)
                RS_ALU:    rf_wdata = MEM_WB_ALU_result_data;
                RS_LOAD:   rf_wdata = load_result;
                RS_LINK:   rf_wdata = link_value;
                RS_MULDIV: rf_wdata = MEM_WB_MulDiv_result_data[31:0];
                default:   rf_wdata = MEM_WB_ALU_result_data;
            endcase
        end
    end

    assign rf_wen    = MEM_WB_wreg_data & ~wb_stall & (MEM_WB_regdst_data != 5'd0);
    assign rf_waddr  = MEM_WB_regdst_data;

    assign hi_we     = MEM_WB_whi_data & ~wb_stall;
    assign lo_we     = MEM_WB_wlo_data & ~wb_stall;
    assign retire_en = ~wb_stall & (MEM_WB_Instruction_data != '0);
    assign hi_next   = MEM_WB_hi_i_sel_data ? MEM_WB_MulDiv_result_data[63:32] : MEM_WB_rf_rdata0_fw_data;
    assign lo_next   = MEM_WB_lo_i_sel_data ? MEM_WB_MulDiv_result_data[31:0]  : MEM_WB_rf_rdata0_fw_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (hi_we)     hi_q  <= hi_next;
            if (lo_we)     lo_q  <= lo_next;
            if (retire_en) cnt_q <= cnt_q + 32'd1;
        end
    end

    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign retire_cnt = cnt_q;
    assign hi_fw      = hi_we ? hi_next : hi_q;
    assign lo_fw      = lo_we ? lo_next : lo_q;

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = MEM_WB_PC_plus4_data - 32'd4;
    assign debug_wb_rf_wen   = {4{rf_wen}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus randomized traffic against an arithmetic model.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [3:0]  lt;
    logic [3:0]  bv;
    logic [1:0]  rsel;
    logic        sc;
    logic        wreg;
    logic        whi;
    logic        wlo;
    logic        hsel;
    logic        lsel;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] rf0;
    logic [31:0] rf1;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [63:0] md;

    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] hi_fw;
    logic [31:0] lo_fw;
    logic [31:0] retire_cnt;

    int          checks;
    int          errors;
    logic [31:0] hi_m;
    logic [31:0] lo_m;
    logic [31:0] cnt_m;

    wb_stage dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .wb_stall                  (stall),
        .MEM_WB_load_type_data     (lt),
        .MEM_WB_byte_valid_data    (bv),
        .MEM_WB_result_sel_data    (rsel),
        .MEM_WB_SC_result_sel_data (sc),
        .MEM_WB_wreg_data          (wreg),
        .MEM_WB_whi_data           (whi),
        .MEM_WB_wlo_data           (wlo),
        .MEM_WB_hi_i_sel_data      (hsel),
        .MEM_WB_lo_i_sel_data      (lsel),
        .MEM_WB_regdst_data        (rd),
        .MEM_WB_ALU_result_data    (alu),
        .MEM_WB_mem_rdata_data     (mem),
        .MEM_WB_rf_rdata0_fw_data  (rf0),
        .MEM_WB_rf_rdata1_fw_data  (rf1),
        .MEM_WB_PC_plus4_data      (pc4),
        .MEM_WB_Instruction_data   (instr),
        .MEM_WB_MulDiv_result_data (md),
        .rf_wen                    (rf_wen),
        .rf_waddr                  (rf_waddr),
        .rf_wdata                  (rf_wdata),
        .hi_o                      (hi_o),
        .lo_o                      (lo_o),
        .hi_fw                     (hi_fw),
        .lo_fw                     (lo_fw),
        .retire_cnt                (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference write data computed from byte arithmetic on the raw inputs.
    function automatic logic [31:0] m_wdata();
        longint unsigned o, m, f, b, h, r, lane;
        o = longint'(alu) % 4;
        m = longint'(mem);
        if (sc) return 32'd1;
        if (rsel == 2'd0) return alu;
        if (rsel == 2'd2) begin
            r = (longint'(pc4) + 4) % 64'h1_0000_0000;
            return r[31:0];
        end
        if (rsel == 2'd3) return md[31:0];
        case (lt)
            4'd1, 4'd2: begin
                b = (m / (64'd1 << (8 * o))) % 256;
                f = (lt == 4'd1 && b >= 128) ? b + 64'hFFFF_FF00 : b;
            end
            4'd3, 4'd4: begin
                h = (m / (64'd1 << (16 * (o / 2)))) % 65536;
                f = (lt == 4'd3 && h >= 32768) ? h + 64'hFFFF_0000 : h;
            end
            4'd5:    f = (m * (64'd1 << (8 * (3 - o)))) % 64'h1_0000_0000;
            4'd6:    f = m / (64'd1 << (8 * o));
            default: f = m;
        endcase
        r = 0;
        for (int i = 0; i < 4; i++) begin
            lane = bv[i] ? (f / (64'd1 << (8 * i))) % 256
                         : (longint'(rf1) / (64'd1 << (8 * i))) % 256;
            r = r + lane * (64'd1 << (8 * i));
        end
        return r[31:0];
    endfunction

    task automatic clear();
        stall = 0; lt = 0; bv = 4'hF; rsel = 0; sc = 0; wreg = 0; whi = 0; wlo = 0;
        hsel = 0; lsel = 0; rd = 0; alu = 0; mem = 0; rf0 = 0; rf1 = 0; pc4 = 0;
        instr = 0; md = 0;
    endtask

    // Called at a negedge with inputs applied; returns at the next negedge.
    task automatic step(input string tag);
        logic [31:0] hn, ln;
        logic        exp_wen;
        #1;
        exp_wen = wreg && !stall && (rd != 5'd0);
        hn = hsel ? md[63:32] : rf0;
        ln = lsel ? md[31:0] : rf0;
        check({tag, ".rf_wen"}, 32'(rf_wen), 32'(exp_wen));
        check({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(rd));
        check({tag, ".rf_wdata"}, rf_wdata, m_wdata());
        check({tag, ".hi_fw"}, hi_fw, (whi && !stall) ? hn : hi_m);
        check({tag, ".lo_fw"}, lo_fw, (wlo && !stall) ? ln : lo_m);
        @(posedge clk);
        if (whi && !stall) hi_m = hn;
        if (wlo && !stall) lo_m = ln;
        if (!stall && instr != 32'd0) cnt_m = cnt_m + 32'd1;
        #1;
        check({tag, ".hi_o"}, hi_o, hi_m);
        check({tag, ".lo_o"}, lo_o, lo_m);
        check({tag, ".retire_cnt"}, retire_cnt, cnt_m);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        hi_m = 0; lo_m = 0; cnt_m = 0;
        rst_n = 0;
        clear();
        @(posedge clk);
        #1;
        check("reset.hi_o", hi_o, 32'd0);
        check("reset.lo_o", lo_o, 32'd0);
        check("reset.retire_cnt", retire_cnt, 32'd0);
        check("reset.rf_wen", 32'(rf_wen), 32'd0);
        check("reset.rf_wdata", rf_wdata, 32'd0);
        check("reset.hi_fw", hi_fw, 32'd0);
        @(negedge clk);
        rst_n = 1;

        // LB / LBU at offset 3
        lt = 4'd1; alu = 32'd3; mem = 32'h8011_2233; wreg = 1; rd = 5'd5; rsel = 2'd1;
        bv = 4'hF; instr = 32'h8000_0003;
        #1;
        check("lb.wen", 32'(rf_wen), 32'd1);
        check("lb.waddr", 32'(rf_waddr), 32'd5);
        check("lb.wdata", rf_wdata, 32'hFFFF_FF80);
        step("lb");
        lt = 4'd2;
        #1 check("lbu.wdata", rf_wdata, 32'h0000_0080);
        step("lbu");

        // LWL merge with forwarded rt
        lt = 4'd5; alu = 32'd1; mem = 32'hAABB_CCDD; rf1 = 32'h1122_3344; bv = 4'b1100;
        #1 check("lwl.wdata", rf_wdata, 32'hCCDD_3344);
        step("lwl");

        // MULT writes both halves at once
        clear();
        whi = 1; wlo = 1; hsel = 1; lsel = 1; md = 64'h0000_0001_0000_0002; instr = 32'h0000_0018;
        #1;
        check("mult.hi_fw", hi_fw, 32'd1);
        check("mult.lo_fw", lo_fw, 32'd2);
        step("mult");
        check("mult.hi_o", hi_o, 32'd1);
        check("mult.lo_o", lo_o, 32'd2);

        // MTHI held in stall for three cycles, then released
        clear();
        whi = 1; rf0 = 32'h5A5A_5A5A; stall = 1; instr = 32'h0000_0011;
        for (int i = 0; i < 3; i++) begin
            #1 check("mthi_stall.hi_fw", hi_fw, 32'd1);
            step("mthi_stall");
            check("mthi_stall.hi_o", hi_o, 32'd1);
        end
        stall = 0;
        step("mthi_go");
        check("mthi_go.hi_o", hi_o, 32'h5A5A_5A5A);
        whi = 0;
        step("mthi_after");
        check("mthi_after.hi_o", hi_o, 32'h5A5A_5A5A);

        // r0 destination, SC success, link values
        clear();
        wreg = 1; rd = 5'd0; alu = 32'h1234_5678; instr = 32'h1;
        #1 check("r0.wen", 32'(rf_wen), 32'd0);
        step("r0");
        rd = 5'd9; sc = 1; rsel = 2'd0;
        #1 check("sc.wdata", rf_wdata, 32'd1);
        step("sc");
        sc = 0; rsel = 2'd2; rd = 5'd31; pc4 = 32'hBFC0_0004;
        #1 check("jal.wdata", rf_wdata, 32'hBFC0_0008);
        step("jal");
        pc4 = 32'hFFFF_FFFC;
        #1 check("jal_wrap.wdata", rf_wdata, 32'h0000_0000);
        step("jal_wrap");

        // Counter wrap from all-ones
        clear();
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1 release dut.cnt_q;
        cnt_m = 32'hFFFF_FFFF;
        check("wrap.preset", retire_cnt, 32'hFFFF_FFFF);
        instr = 32'h2400_0001;
        step("wrap");
        check("wrap.retire_cnt", retire_cnt, 32'd0);
        instr = 32'd0;
        step("bubble");

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            stall = ($urandom % 4) == 0;
            lt    = 4'($urandom % 16);
            bv    = (lt == 4'd0 || lt == 4'd1 || lt == 4'd3 || lt > 4'd6) ? 4'hF : 4'($urandom);
            rsel  = 2'($urandom);
            sc    = ($urandom % 8) == 0;
            wreg  = 1'($urandom);
            whi   = 1'($urandom);
            wlo   = 1'($urandom);
            hsel  = 1'($urandom);
            lsel  = 1'($urandom);
            rd    = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom);
            alu   = $urandom;
            mem   = $urandom;
            rf0   = $urandom;
            rf1   = $urandom;
            pc4   = $urandom;
            instr = (($urandom % 5) == 0) ? 32'd0 : $urandom;
            md    = {$urandom, $urandom};
            step("rnd");
        end

        // Asynchronous reset mid-cycle with a pending HI/LO write
        clear();
        whi = 1; wlo = 1; rf0 = 32'hDEAD_BEEF; instr = 32'h1;
        #2 rst_n = 0;
        hi_m = 0; lo_m = 0; cnt_m = 0;
        #1;
        check("async_rst.hi_o", hi_o, 32'd0);
        check("async_rst.lo_o", lo_o, 32'd0);
        check("async_rst.retire_cnt", retire_cnt, 32'd0);
        @(posedge clk);
        #1;
        check("rst_held.hi_o", hi_o, 32'd0);
        check("rst_held.retire_cnt", retire_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1;
        step("post_rst");
        check("post_rst.hi_o", hi_o, 32'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
